// File: rtl/matrix_checker_pkg.sv
// Shared state type and constants for the matrix output stream checker.
package matrix_checker_pkg;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int MODE_CONST        = 0;
   localparam int MODE_INCR         = 1;
   localparam int FRAME_COUNT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/matrix_stream_checker.sv
// AXI-Stream sink for hardware-in-the-loop self-test: holds off for a start-up window,
// then checks payload and TLAST framing of every beat and counts errors and frames.
module matrix_stream_checker
   import matrix_checker_pkg::*;
#(
   parameter int          DATA_WIDTH     = 32,
   parameter int          CHECK_WIDTH    = 8,
   parameter int unsigned EXPECTED       = 12,
   parameter int          MODE           = MODE_CONST,
   parameter int unsigned STARTUP_CYCLES = 20000,
   parameter int          FRAME_LEN      = 16,
   parameter int unsigned NUM_FRAMES     = 0,
   parameter int          ERR_WIDTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_TVALID,
   input  logic                         in_TLAST,
   input  logic [DATA_WIDTH-1:0]        in_TDATA,
   output logic                         in_TREADY,
   output logic [ERR_WIDTH-1:0]         data_err_count,
   output logic [ERR_WIDTH-1:0]         frame_err_count,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
   output logic                         error_flag,
   output logic                         done
);

   localparam int IDX_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IDX_WIDTH-1:0]   LAST_IDX     = IDX_WIDTH'(FRAME_LEN - 1);
   localparam logic [19:0]            STARTUP_LAST = (STARTUP_CYCLES == 0) ? 20'd0 : 20'(STARTUP_CYCLES - 1);
   localparam logic [CHECK_WIDTH-1:0] EXP_REF      = CHECK_WIDTH'(EXPECTED);

   state_t                 state;
   state_t                 next_state;
   logic [19:0]            startup_cnt;
   logic [IDX_WIDTH-1:0]   beat_idx;
   logic [31:0]            frames_accepted;
   logic                   accept;
   logic                   at_last_idx;
   logic                   frame_end;
   logic                   final_frame;
   logic [CHECK_WIDTH-1:0] ref_now;

   logic                   s1_valid;
   logic                   s1_last;
   logic                   s1_at_last;
   logic [CHECK_WIDTH-1:0] s1_data;
   logic [CHECK_WIDTH-1:0] s1_ref;

   logic                   s2_data_err;
   logic                   s2_frame_err;
   logic                   s2_frame_end;

   logic                   unused_tdata;

   // Ready and done come straight from the state register, so no input reaches an output.
   assign in_TREADY    = (state == S_RUN);
   assign done         = (state == S_DONE);
   assign accept       = in_TVALID & in_TREADY;
   assign at_last_idx  = (beat_idx == LAST_IDX);
   assign frame_end    = accept & (in_TLAST | at_last_idx);
   assign final_frame  = (NUM_FRAMES != 0) && (frames_accepted == 32'(NUM_FRAMES - 1));
   assign unused_tdata = ^in_TDATA;

   always_comb begin
      ref_now = EXP_REF;
      if (MODE == MODE_INCR) begin
         ref_now = EXP_REF + CHECK_WIDTH'(beat_idx);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_WAIT;
         startup_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == S_WAIT) begin
            startup_cnt <= startup_cnt + 20'd1;
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_WAIT: begin
            if ((STARTUP_CYCLES == 0) || (startup_cnt == STARTUP_LAST)) begin
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            if (frame_end && final_frame) begin
               next_state = S_DONE;
            end
         end
         S_DONE:  next_state = S_DONE;
         default: next_state = S_WAIT;
      endcase
   end

   // frames_accepted runs at acceptance time so the halt decision is not delayed by the pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_idx        <= '0;
         frames_accepted <= '0;
      end else if (accept) begin
         if (frame_end) begin
            beat_idx        <= '0;
            frames_accepted <= frames_accepted + 32'd1;
         end else begin
            beat_idx <= beat_idx + IDX_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid     <= 1'b0;
         s1_last      <= 1'b0;
         s1_at_last   <= 1'b0;
         s1_data      <= '0;
         s1_ref       <= '0;
         s2_data_err  <= 1'b0;
         s2_frame_err <= 1'b0;
         s2_frame_end <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_last    <= in_TLAST;
            s1_at_last <= at_last_idx;
            s1_data    <= in_TDATA[CHECK_WIDTH-1:0];
            s1_ref     <= ref_now;
         end
         s2_data_err  <= s1_valid && (s1_data != s1_ref);
         s2_frame_err <= s1_valid && (s1_last != s1_at_last);
         s2_frame_end <= s1_valid && (s1_last || s1_at_last);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= '0;
         error_flag  <= 1'b0;
      end else begin
         if (s2_frame_end) begin
            frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
         end
         error_flag <= error_flag | s2_data_err | s2_frame_err;
      end
   end

   sat_counter #(.WIDTH(ERR_WIDTH)) u_data_err (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (s2_data_err),
      .count   (data_err_count)
   );

   sat_counter #(.WIDTH(ERR_WIDTH)) u_frame_err (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (s2_frame_err),
      .count   (frame_err_count)
   );

endmodule

// File: tb/tb_matrix_stream_checker.sv
// Bench for matrix_stream_checker: instance 0 is constant-mode and free-running,
// instance 1 is incrementing-mode and halts after two frames.
`timescale 1ns/1ps
module tb_matrix_stream_checker;

   localparam int STARTUP = 10;
   localparam int FLEN    = 4;
   localparam int EXPV    = 12;

   typedef struct {
      int due;
      int dut;
      int derr;
      int ferr;
      int fcnt;
      bit eflag;
   } exp_t;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        tvalid [2];
   logic        tlast  [2];
   logic [31:0] tdata  [2];
   logic        tready [2];
   logic [3:0]  derr   [2];
   logic [3:0]  ferr   [2];
   logic [15:0] fcnt   [2];
   logic        eflag  [2];
   logic        done   [2];

   int   tests_run    = 0;
   int   tests_failed = 0;

   exp_t sb[$];
   exp_t mon_e;
   int   mcyc;
   int   midx       [2];
   int   exp_derr   [2];
   int   exp_ferr   [2];
   int   exp_fcnt   [2];
   bit   exp_eflag  [2];
   bit   halted     [2];
   int   frames_acc [2];
   int   acc_count  [2];

   matrix_stream_checker #(
      .DATA_WIDTH(32), .CHECK_WIDTH(8), .EXPECTED(EXPV), .MODE(0),
      .STARTUP_CYCLES(STARTUP), .FRAME_LEN(FLEN), .NUM_FRAMES(0), .ERR_WIDTH(4)
   ) u_dut_const (
      .clk(clk), .reset_n(reset_n),
      .in_TVALID(tvalid[0]), .in_TLAST(tlast[0]), .in_TDATA(tdata[0]), .in_TREADY(tready[0]),
      .data_err_count(derr[0]), .frame_err_count(ferr[0]), .frame_count(fcnt[0]),
      .error_flag(eflag[0]), .done(done[0])
   );

   matrix_stream_checker #(
      .DATA_WIDTH(32), .CHECK_WIDTH(8), .EXPECTED(EXPV), .MODE(1),
      .STARTUP_CYCLES(STARTUP), .FRAME_LEN(FLEN), .NUM_FRAMES(2), .ERR_WIDTH(4)
   ) u_dut_incr (
      .clk(clk), .reset_n(reset_n),
      .in_TVALID(tvalid[1]), .in_TLAST(tlast[1]), .in_TDATA(tdata[1]), .in_TREADY(tready[1]),
      .data_err_count(derr[1]), .frame_err_count(ferr[1]), .frame_count(fcnt[1]),
      .error_flag(eflag[1]), .done(done[1])
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int num_frames_of(input int d);
      return (d == 1) ? 2 : 0;
   endfunction

   task automatic checkOutput(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s (dut%0d) at %0t: got 0x%0h, expected 0x%0h", name, d, $time, got, want);
      end
   endtask

   // Beat-level reference: counters are plain integers updated from the rules, due two edges later.
   task automatic modelBeat(input int d);
      int   refv;
      bit   de;
      bit   fe;
      bit   at_end;
      bit   fend;
      exp_t e;
      refv   = (d == 1) ? (EXPV + midx[d]) % 256 : EXPV;
      at_end = (midx[d] == FLEN - 1);
      de     = (int'(tdata[d][7:0]) != refv);
      fe     = (tlast[d] != at_end);
      fend   = tlast[d] || at_end;
      if (de && exp_derr[d] < 15) exp_derr[d]++;
      if (fe && exp_ferr[d] < 15) exp_ferr[d]++;
      exp_eflag[d] = exp_eflag[d] | de | fe;
      if (fend) begin
         exp_fcnt[d] = (exp_fcnt[d] + 1) % 65536;
         frames_acc[d]++;
         midx[d] = 0;
         if (num_frames_of(d) != 0 && frames_acc[d] == num_frames_of(d)) halted[d] = 1'b1;
      end else begin
         midx[d]++;
      end
      acc_count[d]++;
      e.due   = mcyc + 3;
      e.dut   = d;
      e.derr  = exp_derr[d];
      e.ferr  = exp_ferr[d];
      e.fcnt  = exp_fcnt[d];
      e.eflag = exp_eflag[d];
      sb.push_back(e);
   endtask

   initial begin
      mcyc = 0;
      for (int d = 0; d < 2; d++) begin
         acc_count[d] = 0;
         halted[d]    = 1'b0;
      end
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            mcyc = 0;
            sb.delete();
            for (int d = 0; d < 2; d++) begin
               midx[d]       = 0;
               exp_derr[d]   = 0;
               exp_ferr[d]   = 0;
               exp_fcnt[d]   = 0;
               exp_eflag[d]  = 1'b0;
               halted[d]     = 1'b0;
               frames_acc[d] = 0;
            end
         end else begin
            for (int d = 0; d < 2; d++) begin
               if (tvalid[d] && mcyc >= STARTUP && !halted[d]) modelBeat(d);
            end
            mcyc++;
         end
      end
   end

   initial begin
      #2;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
               checkOutput("reset_outputs", d,
                  32'({tready[d], done[d], eflag[d], derr[d], ferr[d], fcnt[d]}), 32'd0);
            end else begin
               checkOutput("tready", d, 32'(tready[d]), 32'(mcyc >= STARTUP && !halted[d]));
               checkOutput("done", d, 32'(done[d]), 32'(halted[d]));
            end
         end
         while (reset_n && sb.size() > 0 && sb[0].due == mcyc) begin
            mon_e = sb.pop_front();
            checkOutput("data_err_count", mon_e.dut, 32'(derr[mon_e.dut]), 32'(mon_e.derr));
            checkOutput("frame_err_count", mon_e.dut, 32'(ferr[mon_e.dut]), 32'(mon_e.ferr));
            checkOutput("frame_count", mon_e.dut, 32'(fcnt[mon_e.dut]), 32'(mon_e.fcnt));
            checkOutput("error_flag", mon_e.dut, 32'(eflag[mon_e.dut]), 32'(mon_e.eflag));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      for (int d = 0; d < 2; d++) tvalid[d] = 1'b0;
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
   endtask

   task automatic applyStimulus(input int d, input logic [31:0] data, input logic last,
                                input int gap, input int budget, input bit expect_accept);
      int start;
      bit accepted;
      tvalid[d] = 1'b0;
      idle(gap);
      tvalid[d] = 1'b1;
      tdata[d]  = data;
      tlast[d]  = last;
      start     = acc_count[d];
      accepted  = 1'b0;
      for (int i = 0; i < budget && !accepted; i++) begin
         @(posedge clk);
         #1;
         accepted = (acc_count[d] != start);
      end
      tvalid[d] = 1'b0;
      checkOutput("beat_accepted", d, 32'(accepted), 32'(expect_accept));
   endtask

   task automatic checkCounts(input string tag, input int d, input int de, input int fe, input int fc, input int ef);
      checkOutput({tag, "_derr"}, d, 32'(derr[d]), 32'(de));
      checkOutput({tag, "_ferr"}, d, 32'(ferr[d]), 32'(fe));
      checkOutput({tag, "_fcnt"}, d, 32'(fcnt[d]), 32'(fc));
      checkOutput({tag, "_eflag"}, d, 32'(eflag[d]), 32'(ef));
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  low;
      logic        last;
      for (int d = 0; d < 2; d++) begin
         tvalid[d] = 1'b0;
         tlast[d]  = 1'b0;
         tdata[d]  = 32'd0;
      end
      #2;

      // Start-up hold with TVALID high from release, then three clean frames.
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(0, 32'hABCD000C, (i % 4) == 3, 0, 40, 1'b1);
      idle(4);
      checkCounts("clean", 0, 0, 0, 3, 0);

      // Twenty payload errors saturate the data counter.
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(0, 32'h1234560D, (i % 4) == 3, 0, 40, 1'b1);
      idle(4);
      checkCounts("saturate", 0, 15, 0, 5, 1);

      // Early TLAST, missing TLAST, a clean frame, then a beat with both errors.
      doReset();
      applyStimulus(0, 32'h0000000C, 1'b0, 0, 40, 1'b1);
      applyStimulus(0, 32'h0000000C, 1'b1, 0, 40, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0000000C, 1'b0, 0, 40, 1'b1);
      idle(4);
      checkCounts("framing", 0, 0, 2, 2, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0000000C, (i == 3), 0, 40, 1'b1);
      applyStimulus(0, 32'h0000000D, 1'b1, 0, 40, 1'b1);
      idle(4);
      checkCounts("both_err", 0, 1, 3, 4, 1);

      // Randomised payloads, framing and gaps against the reference model.
      doReset();
      for (int i = 0; i < 40; i++) begin
         r    = $urandom();
         low  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'd12;
         last = ((midx[0] == FLEN - 1) ^ ($urandom_range(0, 5) == 0));
         applyStimulus(0, {r[31:8], low}, last, $urandom_range(0, 3), 40, 1'b1);
      end
      idle(4);
      checkCounts("random", 0, exp_derr[0], exp_ferr[0], exp_fcnt[0], 32'(exp_eflag[0]));
      checkOutput("scoreboard_drained", 0, 32'(sb.size()), 32'd0);

      // Reset mid-frame clears everything at once and restarts the start-up window.
      doReset();
      applyStimulus(0, 32'h0000000D, 1'b0, 0, 40, 1'b1);
      applyStimulus(0, 32'h0000000C, 1'b0, 0, 40, 1'b1);
      idle(3);
      checkOutput("pre_reset_derr", 0, 32'(derr[0]), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs", 0,
         32'({tready[0], done[0], eflag[0], derr[0], ferr[0], fcnt[0]}), 32'd0);
      idle(2);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0000000C, (i == 3), 0, 40, 1'b1);
      idle(4);
      checkCounts("after_reset", 0, 0, 0, 1, 0);

      // Incrementing reference with gaps, one bad beat, and the halt after two frames.
      doReset();
      for (int i = 0; i < 4; i++) applyStimulus(1, 32'(EXPV + i), (i == 3), $urandom_range(0, 3), 40, 1'b1);
      idle(4);
      checkCounts("incr_clean", 1, 0, 0, 1, 0);
      applyStimulus(1, 32'd12, 1'b0, $urandom_range(0, 3), 40, 1'b1);
      applyStimulus(1, 32'd13, 1'b0, $urandom_range(0, 3), 40, 1'b1);
      applyStimulus(1, 32'd13, 1'b0, $urandom_range(0, 3), 40, 1'b1);
      applyStimulus(1, 32'd15, 1'b1, $urandom_range(0, 3), 40, 1'b1);
      applyStimulus(1, 32'd12, 1'b0, 0, 20, 1'b0);
      idle(2);
      checkCounts("halt", 1, 1, 0, 2, 1);
      checkOutput("halt_done", 1, 32'(done[1]), 32'd1);
      checkOutput("halt_tready", 1, 32'(tready[1]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
